// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index, FSM states,
// per-cycle decision priority and the bundle of pipeline-register controls.
package hazard_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

  // Which rule governs the current cycle, highest priority first.
  typedef enum logic [2:0] {
    PRIO_RESET   = 3'd0,
    PRIO_HALTED  = 3'd1,
    PRIO_DWAIT   = 3'd2,
    PRIO_BRANCH  = 3'd3,
    PRIO_LOADUSE = 3'd4,
    PRIO_IMISS   = 3'd5,
    PRIO_JUMP    = 3'd6,
    PRIO_RUN     = 3'd7
  } hzprio_t;

  typedef struct packed {
    logic pc_en;
    logic imem_ren;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;
  localparam ctl_t CTL_RUN  = '{pc_en: 1'b1, imem_ren: 1'b1, ifid_en: 1'b1,
                                ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b0,
                                exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signals exchanged between the datapath and the hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     exmem_dREN;
  logic     exmem_dWEN;
  logic     idex_dREN;
  regbits_t idex_rt;
  regbits_t ifid_rs;
  regbits_t ifid_rt;
  logic     ifid_uses_rt;
  logic     ex_branch_taken;
  logic     id_jump;
  logic     memwb_halt;

  logic     pc_en;
  logic     imemREN;
  logic     ifid_en;
  logic     ifid_flush;
  logic     idex_en;
  logic     idex_flush;
  logic     exmem_en;
  logic     exmem_flush;
  logic     memwb_en;
  logic     halt;

  modport ctrl (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, ex_branch_taken, id_jump, memwb_halt,
    output pc_en, imemREN, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halt
  );

  modport dp (
    output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, ex_branch_taken, id_jump, memwb_halt,
    input  pc_en, imemREN, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halt
  );

endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the ID
// instruction forces one bubble. $0 is hardwired and never creates a hazard.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_uses_rt,
  output logic     lu_stall
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rt == ifid_rs);
  assign rt_match = ifid_uses_rt & (idex_rt == ifid_rt);
  assign lu_stall = idex_dREN & (idex_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls, flushes, shared memory port
// arbitration and sticky halt. Define PIPE_STATS_EN to add stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  hazard_ctrl_if.ctrl hz
`ifdef PIPE_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt
`endif
);

  if (STALL_CNT_W < 1) begin : g_bad_width
    $error("hazard_ctrl: STALL_CNT_W must be at least 1");
  end

  hzstate_t state;
  hzstate_t state_nx;
  hzprio_t  prio;
  ctl_t     ctl;
  logic     halt_q;
  logic     lu_stall;
  logic     dreq;
  logic     data_wait;

  hazard_detect u_detect (
    .idex_dREN    (hz.idex_dREN),
    .idex_rt      (hz.idex_rt),
    .ifid_rs      (hz.ifid_rs),
    .ifid_rt      (hz.ifid_rt),
    .ifid_uses_rt (hz.ifid_uses_rt),
    .lu_stall     (lu_stall)
  );

  assign dreq      = hz.exmem_dREN | hz.exmem_dWEN;
  // The data side owns the memory port while waiting, so the whole pipe freezes.
  assign data_wait = (state == DWAIT) | ((state == RUN) & dreq & ~hz.dhit);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list; state updates use <= so every
  // register samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nx;
      halt_q <= (state_nx == HALTED);
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (hz.memwb_halt) begin
      state_nx = HALTED;
    end else begin
      case (state)
        RUN:     if (dreq && !hz.dhit) state_nx = DWAIT;
        DWAIT:   if (hz.dhit)          state_nx = RUN;
        HALTED:                        state_nx = HALTED;
        default:                       state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    prio = PRIO_RUN;
    if (RST)                     prio = PRIO_RESET;
    else if (state == HALTED)    prio = PRIO_HALTED;
    else if (data_wait)          prio = PRIO_DWAIT;
    else if (hz.ex_branch_taken) prio = PRIO_BRANCH;
    else if (lu_stall)           prio = PRIO_LOADUSE;
    else if (!hz.ihit)           prio = PRIO_IMISS;
    else if (hz.id_jump)         prio = PRIO_JUMP;
  end

  // A flush paired with its enable loads a bubble into that pipeline register.
  always_comb begin
    ctl = CTL_IDLE;
    case (prio)
      PRIO_RESET, PRIO_HALTED, PRIO_DWAIT: ctl = CTL_IDLE;
      PRIO_BRANCH: begin
        ctl            = CTL_RUN;
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end
      PRIO_LOADUSE: begin
        ctl            = CTL_RUN;
        ctl.pc_en      = 1'b0;
        ctl.ifid_en    = 1'b0;
        ctl.idex_flush = 1'b1;
      end
      PRIO_IMISS: begin
        ctl            = CTL_RUN;
        ctl.pc_en      = 1'b0;
        ctl.ifid_flush = 1'b1;
      end
      PRIO_JUMP: begin
        ctl            = CTL_RUN;
        ctl.pc_en      = hz.ihit;
        ctl.ifid_flush = 1'b1;
      end
      PRIO_RUN: ctl = CTL_RUN;
      default:  ctl = CTL_IDLE;
    endcase
  end

  assign hz.pc_en       = ctl.pc_en;
  assign hz.imemREN     = ctl.imem_ren;
  assign hz.ifid_en     = ctl.ifid_en;
  assign hz.ifid_flush  = ctl.ifid_flush;
  assign hz.idex_en     = ctl.idex_en;
  assign hz.idex_flush  = ctl.idex_flush;
  assign hz.exmem_en    = ctl.exmem_en;
  assign hz.exmem_flush = ctl.exmem_flush;
  assign hz.memwb_en    = ctl.memwb_en;
  assign hz.halt        = halt_q;

`ifdef PIPE_STATS_EN
  logic any_flush;
  assign any_flush = ctl.ifid_flush | ctl.idex_flush | ctl.exmem_flush;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl.pc_en && state != HALTED && !(&stall_cnt))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (any_flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expected controls from a rule-level reference model, checked by a monitor.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  hazard_ctrl_if hz ();

`ifdef PIPE_STATS_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       idex_dren;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       uses_rt;
    logic       br;
    logic       jmp;
    logic       halt_in;
  } stim_t;

  typedef struct {
    logic [9:0]    v;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   running = 1'b0;

  // Reference model: whether the processor is halted, whether it is parked
  // waiting on data memory, and the two saturating statistics.
  bit            m_halted = 1'b0;
  bit            m_waiting = 1'b0;
  logic [CW-1:0] m_sc = '0;
  logic [CW-1:0] m_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    logic pc, im, ie, ifl, xe, xfl, me, mfl, we;
    bit   dwait, lu;
    @(posedge CLK);
    #1;
    RST                = s.rst;
    hz.ihit            = s.ihit;
    hz.dhit            = s.dhit;
    hz.exmem_dREN      = s.dren;
    hz.exmem_dWEN      = s.dwen;
    hz.idex_dREN       = s.idex_dren;
    hz.idex_rt         = s.idex_rt;
    hz.ifid_rs         = s.ifid_rs;
    hz.ifid_rt         = s.ifid_rt;
    hz.ifid_uses_rt    = s.uses_rt;
    hz.ex_branch_taken = s.br;
    hz.id_jump         = s.jmp;
    hz.memwb_halt      = s.halt_in;

    {pc, im, ie, ifl, xe, xfl, me, mfl, we} = '0;
    dwait = m_waiting || ((s.dren || s.dwen) && !s.dhit);
    lu    = s.idex_dren && (s.idex_rt != 0) &&
            ((s.idex_rt == s.ifid_rs) || (s.uses_rt && s.idex_rt == s.ifid_rt));
    if (!s.rst && !m_halted && !dwait) begin
      {pc, im, ie, xe, me, we} = '1;
      if (s.br) begin
        ifl = 1'b1;
        xfl = 1'b1;
      end else if (lu) begin
        pc  = 1'b0;
        ie  = 1'b0;
        xfl = 1'b1;
      end else if (!s.ihit) begin
        pc  = 1'b0;
        ifl = 1'b1;
      end else if (s.jmp) begin
        ifl = 1'b1;
      end
    end
    e.v   = {pc, im, ie, ifl, xe, xfl, me, mfl, we, m_halted};
    e.sc  = m_sc;
    e.fc  = m_fc;
    e.tag = tag;
    sb.push_back(e);
    running = 1'b1;

    if (s.rst) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (!pc && !m_halted && m_sc != '1) m_sc = m_sc + 1'b1;
      if ((ifl || xfl || mfl) && m_fc != '1) m_fc = m_fc + 1'b1;
    end

    if (s.rst) begin
      m_halted  = 1'b0;
      m_waiting = 1'b0;
    end else if (m_halted) begin
      m_waiting = 1'b0;
    end else if (s.halt_in) begin
      m_halted  = 1'b1;
      m_waiting = 1'b0;
    end else if (m_waiting) begin
      m_waiting = !s.dhit;
    end else begin
      m_waiting = (s.dren || s.dwen) && !s.dhit;
    end
  endtask

  // Monitor: the controller presents a full set of controls every cycle.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hz.pc_en, hz.imemREN, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
               hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.halt};
        check(e.tag, 32'(act), 32'(e.v));
`ifdef PIPE_STATS_EN
        check({e.tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        check({e.tag, "_flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
`endif
      end else if (running) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underrun: got empty queue expected one entry per cycle");
      end
    end
  end

  initial begin
    stim_t s;
    {hz.ihit, hz.dhit, hz.exmem_dREN, hz.exmem_dWEN, hz.idex_dREN} = '0;
    {hz.idex_rt, hz.ifid_rs, hz.ifid_rt} = '0;
    {hz.ifid_uses_rt, hz.ex_branch_taken, hz.id_jump, hz.memwb_halt} = '0;

    s = idle(); s.rst = 1'b1;
    step(s, "reset0");
    step(s, "reset1");
    step(idle(), "run_idle");

    s = idle(); s.idex_dren = 1'b1; s.idex_rt = 5'd5; s.ifid_rs = 5'd5;
    step(s, "load_use_rs");
    step(idle(), "load_use_after");
    s = idle(); s.idex_dren = 1'b1; s.idex_rt = 5'd7; s.ifid_rt = 5'd7; s.uses_rt = 1'b1;
    step(s, "load_use_rt");
    s.uses_rt = 1'b0;
    step(s, "load_rt_unused");
    s = idle(); s.idex_dren = 1'b1;
    step(s, "load_use_r0");

    s = idle(); s.dren = 1'b1;
    step(s, "dwait_1");
    step(s, "dwait_2");
    step(s, "dwait_3");
    s.dhit = 1'b1;
    step(s, "dwait_hit");
    step(s, "dwait_resume");
    step(idle(), "dwait_idle");

    s = idle(); s.br = 1'b1; s.idex_dren = 1'b1; s.idex_rt = 5'd3; s.ifid_rs = 5'd3;
    step(s, "branch_over_lu");
    s = idle(); s.jmp = 1'b1;
    step(s, "jump");
    s.ihit = 1'b0;
    step(s, "jump_imiss");
    for (int i = 0; i < 20; i++) begin
      s = idle(); s.ihit = 1'b0;
      step(s, "imiss_saturate");
    end

    s = idle(); s.dwen = 1'b1; s.halt_in = 1'b1;
    step(s, "halt_in_dwait");
    s = idle(); s.dwen = 1'b1;
    step(s, "halted_1");
    step(idle(), "halted_2");
    s = idle(); s.rst = 1'b1;
    step(s, "halt_reset");
    step(idle(), "after_halt_reset");

    for (int i = 0; i < 3000; i++) begin
      s           = '0;
      s.rst       = ($urandom_range(0, 99) == 0);
      s.ihit      = ($urandom_range(0, 99) < 85);
      s.dhit      = 1'($urandom_range(0, 1));
      s.dren      = ($urandom_range(0, 99) < 20);
      s.dwen      = !s.dren && ($urandom_range(0, 99) < 10);
      s.idex_dren = ($urandom_range(0, 99) < 40);
      s.idex_rt   = 5'($urandom_range(0, 3));
      s.ifid_rs   = 5'($urandom_range(0, 3));
      s.ifid_rt   = 5'($urandom_range(0, 3));
      s.uses_rt   = 1'($urandom_range(0, 1));
      s.br        = ($urandom_range(0, 99) < 15);
      s.jmp       = ($urandom_range(0, 99) < 10);
      s.halt_in   = ($urandom_range(0, 299) == 0);
      step(s, "random");
    end

    running = 1'b0;
    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
